watch_set_ctrl: RTL and testbench

Time-setting controller that sequences the watch counter datapath. It sits between the user button inputs and the watch counter. It freezes counting while the user edits sec/min/hour/day fields in a shadow register, then commits the edited time with a single-cycle load strobe. In RUN mode it passes the run enable through. In set modes it holds the counter stopped.

---
 rtl/watch_pkg.sv | 25 ++
 rtl/watch_field_step.sv | 25 ++
 rtl/watch_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_watch_set_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared state/mode encodings and field limits for the watch
// time-setting controller and its display logic.
package watch_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_SEC  = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_HOUR = 3'd3,
        ST_SET_DAY  = 3'd4,
        ST_COMMIT   = 3'd5
    } state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam logic [2:0] MODE_RUN      = ST_RUN;
    localparam logic [2:0] MODE_SET_SEC  = ST_SET_SEC;
    localparam logic [2:0] MODE_SET_MIN  = ST_SET_MIN;
    localparam logic [2:0] MODE_SET_HOUR = ST_SET_HOUR;
    localparam logic [2:0] MODE_SET_DAY  = ST_SET_DAY;
    localparam logic [2:0] MODE_COMMIT   = ST_COMMIT;

endpackage

// File: rtl/watch_field_step.sv
// Combinational +/-1 on one time field with explicit wrap at 0 and MAX.
module watch_field_step #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] TOP  = W'(MAX);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    always_comb begin
        nxt = val;
        unique case (1'b1)
            (inc && !dec): nxt = (val == TOP)  ? ZERO : val + ONE;
            (dec && !inc): nxt = (val == ZERO) ? TOP  : val - ONE;
            default:       nxt = val;
        endcase
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting sequencer: freezes the watch counter, edits a shadow copy
// of the time, then commits it with a one-cycle load strobe.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5,
    parameter int P_DAY_BIT  = 9,
    parameter int P_DAY_MAX  = 365,
    parameter int P_TO_BIT   = 30,
    parameter int P_TIMEOUT  = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run_en,
    input  logic                  i_mode,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic                  i_cancel,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    input  logic [P_DAY_BIT-1:0]  i_day,
    output logic                  o_run_en,
    output logic                  o_load,
    output logic [P_SEC_BIT-1:0]  o_sec,
    output logic [P_MIN_BIT-1:0]  o_min,
    output logic [P_HOUR_BIT-1:0] o_hour,
    output logic [P_DAY_BIT-1:0]  o_day,
    output logic [2:0]            o_mode
);

    localparam logic [P_SEC_BIT-1:0]  SEC_LIM  = P_SEC_BIT'(SEC_MAX);
    localparam logic [P_MIN_BIT-1:0]  MIN_LIM  = P_MIN_BIT'(MIN_MAX);
    localparam logic [P_HOUR_BIT-1:0] HOUR_LIM = P_HOUR_BIT'(HOUR_MAX);
    localparam logic [P_DAY_BIT-1:0]  DAY_LIM  = P_DAY_BIT'(P_DAY_MAX);
    localparam logic [P_TO_BIT-1:0]   TO_LAST  = P_TO_BIT'(P_TIMEOUT - 1);
    localparam logic [P_TO_BIT-1:0]   TO_ONE   = P_TO_BIT'(1);

    logic [2:0]            state;
    logic [P_TO_BIT-1:0]   to_cnt;
    logic [P_SEC_BIT-1:0]  sh_sec;
    logic [P_MIN_BIT-1:0]  sh_min;
    logic [P_HOUR_BIT-1:0] sh_hour;
    logic [P_DAY_BIT-1:0]  sh_day;

    logic [P_SEC_BIT-1:0]  nx_sec;
    logic [P_MIN_BIT-1:0]  nx_min;
    logic [P_HOUR_BIT-1:0] nx_hour;
    logic [P_DAY_BIT-1:0]  nx_day;

    logic in_set;
    logic cancel;
    logic edit;
    logic ed_sec, ed_min, ed_hour, ed_day;

    assign in_set = (state == MODE_SET_SEC)
                 || (state == MODE_SET_MIN)
                 || (state == MODE_SET_HOUR)
                 || (state == MODE_SET_DAY);

    // an expiring idle timer acts exactly like a user cancel
    assign cancel = in_set && (i_cancel || (to_cnt == TO_LAST));
    assign edit   = in_set && !cancel && !i_mode;

    assign ed_sec  = edit && (state == MODE_SET_SEC);
    assign ed_min  = edit && (state == MODE_SET_MIN);
    assign ed_hour = edit && (state == MODE_SET_HOUR);
    assign ed_day  = edit && (state == MODE_SET_DAY);

    watch_field_step #(.W(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
        .val(sh_sec), .inc(ed_sec && i_inc),
        .dec(ed_sec && i_dec), .nxt(nx_sec)
    );

    watch_field_step #(.W(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
        .val(sh_min), .inc(ed_min && i_inc),
        .dec(ed_min && i_dec), .nxt(nx_min)
    );

    watch_field_step #(.W(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
        .val(sh_hour), .inc(ed_hour && i_inc),
        .dec(ed_hour && i_dec), .nxt(nx_hour)
    );

    watch_field_step #(.W(P_DAY_BIT), .MAX(P_DAY_MAX)) u_day (
        .val(sh_day), .inc(ed_day && i_inc),
        .dec(ed_day && i_dec), .nxt(nx_day)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= MODE_RUN;
            to_cnt   <= '0;
            sh_sec   <= '0;
            sh_min   <= '0;
            sh_hour  <= '0;
            sh_day   <= '0;
            o_load   <= 1'b0;
            o_run_en <= 1'b0;
        end else begin
            o_load <= 1'b0;
            case (state)
                MODE_RUN: begin
                    o_run_en <= i_run_en;
                    to_cnt   <= '0;
                    if (i_mode) begin
                        state    <= MODE_SET_SEC;
                        o_run_en <= 1'b0;
                        sh_sec   <= (i_sec  > SEC_LIM)  ? '0 : i_sec;
                        sh_min   <= (i_min  > MIN_LIM)  ? '0 : i_min;
                        sh_hour  <= (i_hour > HOUR_LIM) ? '0 : i_hour;
                        sh_day   <= (i_day  > DAY_LIM)  ? '0 : i_day;
                    end
                end
                MODE_SET_SEC, MODE_SET_MIN,
                MODE_SET_HOUR, MODE_SET_DAY: begin
                    o_run_en <= 1'b0;
                    if (cancel) begin
                        state  <= MODE_RUN;
                        to_cnt <= '0;
                    end else if (i_mode) begin
                        state  <= state + 3'd1;
                        o_load <= (state == MODE_SET_DAY);
                        to_cnt <= '0;
                    end else begin
                        sh_sec  <= nx_sec;
                        sh_min  <= nx_min;
                        sh_hour <= nx_hour;
                        sh_day  <= nx_day;
                        to_cnt  <= (i_inc || i_dec) ? '0
                                                    : to_cnt + TO_ONE;
                    end
                end
                MODE_COMMIT: begin
                    state    <= MODE_RUN;
                    o_run_en <= 1'b0;
                    to_cnt   <= '0;
                end
                default: begin
                    state    <= MODE_RUN;
                    o_run_en <= 1'b0;
                    to_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_sec  = sh_sec;
    assign o_min  = sh_min;
    assign o_hour = sh_hour;
    assign o_day  = sh_day;
    assign o_mode = state;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Randomized bench for watch_set_ctrl against a field-array reference
// model, plus directed edge cases for wrap, commit, cancel and timeout.
module tb_watch_set_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_run_en, i_mode, i_inc, i_dec, i_cancel;
    logic [5:0] i_sec, i_min;
    logic [4:0] i_hour;
    logic [8:0] i_day;
    logic       o_run_en, o_load;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [8:0] o_day;
    logic [2:0] o_mode;

    always #5 clk = ~clk;

    watch_set_ctrl #(.P_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_run_en(i_run_en), .i_mode(i_mode),
        .i_inc(i_inc), .i_dec(i_dec), .i_cancel(i_cancel),
        .i_sec(i_sec), .i_min(i_min),
        .i_hour(i_hour), .i_day(i_day),
        .o_run_en(o_run_en), .o_load(o_load),
        .o_sec(o_sec), .o_min(o_min),
        .o_hour(o_hour), .o_day(o_day),
        .o_mode(o_mode)
    );

    int total = 0;
    int bad   = 0;

    int m_mode, m_run, m_load, m_idle;
    int fld[4];
    int fmax[4] = '{59, 59, 23, 365};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_load = 0; m_idle = 0;
        for (int k = 0; k < 4; k++) fld[k] = 0;
    endtask

    // one clock edge of the watch-setting rules, in plain integers
    task automatic model_step();
        bit inset;
        bit canc;
        int k;
        inset  = (m_mode >= 1) && (m_mode <= 4);
        canc   = inset && (i_cancel || (m_idle == TO - 1));
        m_load = 0;
        if (m_mode == 0) begin
            m_run  = i_run_en;
            m_idle = 0;
            if (i_mode) begin
                m_mode = 1;
                m_run  = 0;
                fld[0] = (i_sec  > 59)  ? 0 : int'(i_sec);
                fld[1] = (i_min  > 59)  ? 0 : int'(i_min);
                fld[2] = (i_hour > 23)  ? 0 : int'(i_hour);
                fld[3] = (i_day  > 365) ? 0 : int'(i_day);
            end
        end else if (m_mode == 5) begin
            m_mode = 0;
            m_run  = 0;
            m_idle = 0;
        end else begin
            m_run = 0;
            if (canc) begin
                m_mode = 0;
                m_idle = 0;
            end else if (i_mode) begin
                m_load = (m_mode == 4);
                m_mode = m_mode + 1;
                m_idle = 0;
            end else begin
                k = m_mode - 1;
                if (i_inc && !i_dec)
                    fld[k] = (fld[k] + 1) % (fmax[k] + 1);
                else if (i_dec && !i_inc)
                    fld[k] = (fld[k] + fmax[k]) % (fmax[k] + 1);
                m_idle = (i_inc || i_dec) ? 0 : m_idle + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mode"}, 32'(o_mode),   m_mode);
        check({tag, ".run"},  32'(o_run_en), m_run);
        check({tag, ".load"}, 32'(o_load),   m_load);
        check({tag, ".sec"},  32'(o_sec),    fld[0]);
        check({tag, ".min"},  32'(o_min),    fld[1]);
        check({tag, ".hour"}, 32'(o_hour),   fld[2]);
        check({tag, ".day"},  32'(o_day),    fld[3]);
    endtask

    // called at a negedge: drive, clock once, compare at the next negedge
    task automatic cyc(input logic r, input logic m, input logic inc,
                       input logic dec, input logic c);
        i_run_en = r; i_mode = m; i_inc = inc;
        i_dec = dec; i_cancel = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all("cyc");
    endtask

    initial begin
        int n;
        reset = 1'b0;
        i_run_en = 1'b1; i_mode = 1'b0; i_inc = 1'b0;
        i_dec = 1'b0; i_cancel = 1'b0;
        i_sec = '0; i_min = '0; i_hour = '0; i_day = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_run",  32'(o_run_en), 0);
        check("rst_load", 32'(o_load),   0);
        check("rst_mode", 32'(o_mode),   0);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check("run_lat", 32'(o_run_en), 1);

        i_sec = 6'd58; i_min = 6'd59; i_hour = 5'd23; i_day = 9'd365;
        cyc(1, 1, 0, 0, 0);
        check("enter_mode", 32'(o_mode),   1);
        check("enter_run",  32'(o_run_en), 0);
        cyc(1, 0, 1, 0, 0);
        check("sec_59", 32'(o_sec), 59);
        cyc(1, 0, 1, 0, 0);
        check("sec_wrap", 32'(o_sec), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("hour_up_wrap", 32'(o_hour), 0);
        cyc(1, 0, 0, 1, 0);
        check("hour_dn_wrap", 32'(o_hour), 23);
        cyc(1, 1, 1, 0, 0);
        check("mode_beats_inc", 32'(o_hour), 23);
        check("day_captured", 32'(o_day), 365);
        cyc(1, 0, 1, 0, 0);
        check("day_wrap", 32'(o_day), 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        check("inc_dec_hold", 32'(o_day), 365);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        check("commit_load", 32'(o_load), 1);
        check("commit_mode", 32'(o_mode), 5);
        check("commit_day",  32'(o_day),  364);
        cyc(1, 0, 0, 0, 0);
        check("post_mode", 32'(o_mode),   0);
        check("post_run",  32'(o_run_en), 0);
        cyc(1, 0, 0, 0, 0);
        check("post_run1", 32'(o_run_en), 1);

        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("cancel_mode", 32'(o_mode), 0);
        check("cancel_load", 32'(o_load), 0);

        cyc(1, 1, 0, 0, 0);
        n = 0;
        while (o_mode != 3'd0 && n < 20) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        check("timeout_cycles", n, TO);

        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("in_set_day", 32'(o_mode), 4);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_held");
        reset = 1'b1;

        for (int t = 0; t < 3000; t++) begin
            i_sec  = 6'($urandom_range(0, 63));
            i_min  = 6'($urandom_range(0, 63));
            i_hour = 5'($urandom_range(0, 31));
            i_day  = 9'($urandom_range(0, 511));
            cyc(($urandom_range(0, 7) != 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
